stage_sequencer: RTL and testbench

Handshake-driven power-up/reset sequencer for the pipeline stages (mem, pe, 3x3, 2x2, display). Stages are released one at a time in a thermometer pattern. A stage is released only after the previous stage reports done, with a settle gap between releases and a per-stage watchdog timeout. It sits at the top level, takes a start/abort command, and drives one enable per stage plus status.

---
 rtl/stage_seq_pkg.sv | 17 +
 rtl/seq_timer.sv | 34 +++
 rtl/stage_sequencer.sv | 158 +++++++++++++++
 tb/tb_stage_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_seq_pkg.sv
// Shared types and default timing constants for the stage power-up sequencer.
package stage_seq_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StSettle = 3'd1,
    StWait   = 3'd2,
    StFinish = 3'd3,
    StError  = 3'd4
  } state_e;

  localparam int unsigned ClkHz          = 100_000_000;
  localparam int unsigned SettleDefault  = 4;
  // Five seconds at the system clock rate.
  localparam int unsigned TimeoutDefault = 5 * ClkHz;

endpackage

// File: rtl/seq_timer.sv
// Saturating counter with synchronous clear/increment and a compare-equal flag.
module seq_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] cmp,
  output logic         eq
);

  logic [W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign eq = (count_q == cmp);

endmodule

// File: rtl/stage_sequencer.sv
// Thermometer power-up sequencer: releases stages one at a time with settle gap and watchdog.
// Optional macro STAGE_SKIP_EN adds a skip_mask input that releases marked stages without waiting.
module stage_sequencer
  import stage_seq_pkg::*;
#(
  parameter int unsigned N_STAGE = 5,
  parameter int unsigned SETTLE  = SettleDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault,
  parameter int unsigned TMO_W   = 32,
  localparam int unsigned IDX_W  = (N_STAGE > 1) ? $clog2(N_STAGE) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [N_STAGE-1:0] stage_done,
`ifdef STAGE_SKIP_EN
  input  logic [N_STAGE-1:0] skip_mask,
`endif
  output logic [N_STAGE-1:0] stage_en,
  output logic [IDX_W-1:0]   cur_stage,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [IDX_W-1:0]   err_stage
);

  state_e             state_d, state_q;
  logic [N_STAGE-1:0] en_d, en_q;
  logic [IDX_W-1:0]   cur_d, cur_q;
  logic [IDX_W-1:0]   err_stage_d, err_stage_q;
  logic               busy_d, busy_q, done_d, done_q, err_d, err_q;

  logic               tmr_clr, tmr_inc, tmr_eq;
  logic [TMO_W-1:0]   tmr_cmp;
  logic [N_STAGE-1:0] skip, stage_bit;
  logic               cur_done, last;

`ifdef STAGE_SKIP_EN
  assign skip = skip_mask;
`else
  assign skip = '0;
`endif

  assign stage_bit = N_STAGE'(1) << cur_q;
  assign cur_done  = stage_done[cur_q] | skip[cur_q];
  assign last      = (cur_q == IDX_W'(N_STAGE - 1));
  // One timer serves both the settle gap and the watchdog.
  assign tmr_cmp   = (state_q == StWait) ? TMO_W'(TIMEOUT - 1) : TMO_W'(SETTLE - 1);

  seq_timer #(
    .W(TMO_W)
  ) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(tmr_clr),
    .inc(tmr_inc),
    .cmp(tmr_cmp),
    .eq (tmr_eq)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      en_q        <= '0;
      cur_q       <= '0;
      err_stage_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_q        <= en_d;
      cur_q       <= cur_d;
      err_stage_q <= err_stage_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    en_d        = en_q;
    cur_d       = cur_q;
    err_stage_d = err_stage_q;
    tmr_clr     = 1'b0;
    tmr_inc     = 1'b0;
    if (abort) begin
      state_d = StIdle;
      en_d    = '0;
      cur_d   = '0;
      tmr_clr = 1'b1;
    end else begin
      case (state_q)
        StIdle, StFinish: begin
          if (start) begin
            state_d     = StSettle;
            en_d        = '0;
            cur_d       = '0;
            err_stage_d = '0;
            tmr_clr     = 1'b1;
          end
        end
        StSettle: begin
          if (skip[cur_q] || tmr_eq) begin
            en_d    = en_q | stage_bit;
            tmr_clr = 1'b1;
            // A skipped stage counts as done in the same edge it is released.
            if (!skip[cur_q]) begin
              state_d = StWait;
            end else if (last) begin
              state_d = StFinish;
            end else begin
              cur_d = cur_q + 1'b1;
            end
          end else begin
            tmr_inc = 1'b1;
          end
        end
        StWait: begin
          if (cur_done) begin
            tmr_clr = 1'b1;
            if (last) begin
              state_d = StFinish;
            end else begin
              state_d = StSettle;
              cur_d   = cur_q + 1'b1;
            end
          end else if (tmr_eq) begin
            state_d     = StError;
            err_stage_d = cur_q;
            en_d        = '0;
            tmr_clr     = 1'b1;
          end else begin
            tmr_inc = 1'b1;
          end
        end
        StError: ;
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    busy_d = (state_d == StSettle) || (state_d == StWait);
    done_d = (state_d == StFinish);
    err_d  = (state_d == StError);
  end

  assign stage_en  = en_q;
  assign cur_stage = cur_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_stage = err_stage_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Randomized self-checking bench for stage_sequencer against a phase/timestamp model.
module tb_stage_sequencer;

  localparam int N         = 5;
  localparam int SETTLE_C  = 2;
  localparam int TIMEOUT_C = 16;
  localparam int IW        = $clog2(N);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [N-1:0]  stage_done = '0;
  logic [N-1:0]  stage_en;
  logic [IW-1:0] cur_stage, err_stage;
  logic          busy, done, err;
  logic [N-1:0]  skp;

`ifdef STAGE_SKIP_EN
  logic [N-1:0] skip_mask = '0;
  assign skp = skip_mask;
`else
  assign skp = '0;
`endif

  stage_sequencer #(
    .N_STAGE(N),
    .SETTLE (SETTLE_C),
    .TIMEOUT(TIMEOUT_C),
    .TMO_W  (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .stage_done(stage_done),
`ifdef STAGE_SKIP_EN
    .skip_mask (skip_mask),
`endif
    .stage_en  (stage_en),
    .cur_stage (cur_stage),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_stage (err_stage)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase, count of released stages and phase-entry timestamp.
  typedef enum {MIdle, MSettle, MWait, MFinish, MError} mphase_e;
  mphase_e m_phase = MIdle;
  int      m_stage = 0;
  int      m_released = 0;
  int      m_err_stage = 0;
  longint  cyc = 0;
  longint  m_since = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_phase     <= MIdle;
      m_stage     <= 0;
      m_released  <= 0;
      m_err_stage <= 0;
      m_since     <= 0;
      cyc         <= 0;
    end else begin
      cyc <= cyc + 1;
      if (abort) begin
        m_phase    <= MIdle;
        m_stage    <= 0;
        m_released <= 0;
      end else begin
        case (m_phase)
          MIdle, MFinish: if (start) begin
            m_phase     <= MSettle;
            m_stage     <= 0;
            m_released  <= 0;
            m_err_stage <= 0;
            m_since     <= cyc + 1;
          end
          MSettle: begin
            if (skp[m_stage]) begin
              m_released <= m_stage + 1;
              if (m_stage == N - 1) m_phase <= MFinish;
              else begin
                m_stage <= m_stage + 1;
                m_since <= cyc + 1;
              end
            end else if (cyc - m_since == SETTLE_C - 1) begin
              m_released <= m_stage + 1;
              m_phase    <= MWait;
              m_since    <= cyc + 1;
            end
          end
          MWait: begin
            if (stage_done[m_stage] || skp[m_stage]) begin
              if (m_stage == N - 1) m_phase <= MFinish;
              else begin
                m_phase <= MSettle;
                m_stage <= m_stage + 1;
                m_since <= cyc + 1;
              end
            end else if (cyc - m_since == TIMEOUT_C - 1) begin
              m_phase     <= MError;
              m_err_stage <= m_stage;
              m_released  <= 0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  int delay [N];
  int age [N];
  int hang = -1;
  bit noise_on = 1'b0;
  bit start_noise = 1'b0;
  int handshakes = 0;

  task automatic check_outputs();
    logic [N-1:0] exp_en;
    exp_en = '0;
    for (int i = 0; i < m_released; i++) exp_en[i] = 1'b1;
    check_eq("stage_en", stage_en, exp_en);
    check_eq("cur_stage", cur_stage, m_stage);
    check_eq("busy", busy, (m_phase == MSettle) || (m_phase == MWait));
    check_eq("done", done, m_phase == MFinish);
    check_eq("err", err, m_phase == MError);
    check_eq("err_stage", err_stage, m_err_stage);
  endtask

  // Stage responder: pulses done delay[i] cycles after the stage is seen enabled.
  task automatic respond();
    int hi;
    hi = -1;
    for (int i = 0; i < N; i++) if (stage_en[i]) hi = i;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < N; i++) begin
      age[i] = stage_en[i] ? age[i] + 1 : -1;
      stage_done[i] = 1'b0;
      if (age[i] == delay[i] && i != hang && !skp[i]) begin
        stage_done[i] = 1'b1;
        handshakes++;
      end else if (noise_on && i < hi) begin
        stage_done[i] = 1'($urandom_range(0, 1));
      end
    end
    if (start_noise && (busy || err) && $urandom_range(0, 15) == 0) start = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
    respond();
  endtask

  task automatic run_to_end(input int max_cyc);
    int n;
    n = 0;
    while (!done && !err && n < max_cyc) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    bit err_seen;
    for (int i = 0; i < N; i++) begin
      delay[i] = 3;
      age[i]   = -1;
    end

    repeat (3) step();
    check_eq("rst_en", stage_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err_stage", err_stage, 0);
    rst = 1'b1;

    // Clean sequence
    start = 1'b1;
    step();
    run_to_end(200);
    check_eq("seq_done", done, 1);
    check_eq("seq_en", stage_en, 5'b11111);
    check_eq("seq_busy", busy, 0);

    // Stage 2 hangs: watchdog, start ignored, abort recovers
    hang = 2;
    start = 1'b1;
    step();
    check_eq("restart_en", stage_en, 0);
    n = 0;
    while (!stage_en[2] && n < 200) begin
      step();
      n++;
    end
    check_eq("en2_seen", stage_en[2], 1);
    n = 0;
    while (!err && n < 100) begin
      step();
      n++;
    end
    check_eq("tmo_latency", n, TIMEOUT_C);
    check_eq("tmo_err_stage", err_stage, 2);
    check_eq("tmo_en", stage_en, 0);
    check_eq("tmo_busy", busy, 0);
    start = 1'b1;
    step();
    repeat (3) step();
    check_eq("err_ignores_start", err, 1);
    abort = 1'b1;
    step();
    check_eq("abort_err", err, 0);
    check_eq("abort_keeps_err_stage", err_stage, 2);
    hang = -1;

    // Stage 1 done exactly on the last watchdog cycle
    delay[1] = TIMEOUT_C - 1;
    start = 1'b1;
    step();
    err_seen = 1'b0;
    n = 0;
    while (!done && n < 300) begin
      step();
      err_seen |= err;
      n++;
    end
    check_eq("edge_done", done, 1);
    check_eq("edge_no_err", err_seen, 0);
    delay[1] = 3;

    // Abort while waiting on stage 3, then stray done bits
    delay[3] = 10;
    start = 1'b1;
    step();
    n = 0;
    while (!stage_en[3] && n < 200) begin
      step();
      n++;
    end
    check_eq("en3_seen", stage_en[3], 1);
    abort = 1'b1;
    step();
    check_eq("abort_en", stage_en, 0);
    check_eq("abort_busy", busy, 0);
    repeat (20) begin
      step();
      stage_done[2:0] = 3'($urandom);
    end
    check_eq("post_abort_en", stage_en, 0);
    delay[3] = 3;

    // Asynchronous reset mid-settle
    start = 1'b1;
    step();
    step();
    #2 rst = 1'b0;
    #1;
    check_eq("arst_en", stage_en, 0);
    check_eq("arst_cur", cur_stage, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_done", done, 0);
    check_eq("arst_err", err, 0);
    check_eq("arst_err_stage", err_stage, 0);
    step();
    step();
    rst = 1'b1;
    start = 1'b1;
    step();
    run_to_end(200);
    check_eq("post_rst_done", done, 1);
    check_eq("post_rst_en", stage_en, 5'b11111);

    // Randomized sequences
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) delay[i] = $urandom_range(0, 6);
      hang = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1)) : -1;
      noise_on = 1'b1;
      start_noise = 1'b1;
      start = 1'b1;
      step();
      run_to_end(400);
      check_eq("rnd_end", done | err, 1);
      check_eq("rnd_outcome", err, hang >= 0);
      start_noise = 1'b0;
      if (err) begin
        abort = 1'b1;
        step();
      end
    end
    noise_on = 1'b0;
    hang = -1;
    for (int i = 0; i < N; i++) delay[i] = 3;

`ifdef STAGE_SKIP_EN
    begin
      int t1, t2;
      abort = 1'b1;
      step();
      skip_mask = 5'b00110;
      handshakes = 0;
      t1 = -1;
      t2 = -1;
      start = 1'b1;
      step();
      n = 0;
      while (!done && n < 200) begin
        step();
        n++;
        if (stage_en[1] && t1 < 0) t1 = n;
        if (stage_en[2] && t2 < 0) t2 = n;
      end
      check_eq("skip_done", done, 1);
      check_eq("skip_handshakes", handshakes, 3);
      check_eq("skip_consecutive", t2 - t1, 1);
      skip_mask = '0;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
